imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: streams bytes from a byte source into instruction memory as
// little-endian 32-bit words, holding the CPU in reset while loading.
// Optional build macro IMEM_LOADER_CHECKSUM_EN adds a running XOR over all
// data bytes and a trailing checksum byte that sets err on mismatch.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_len,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    CHECK,
    DONE
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE,
    RECV,
    WRITE,
    DONE
  } state_t;
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        cnt_q;
  logic [31:0]       word_q;
  logic              last_word;

  // len_q of 0 means a full memory; len_q-1 then wraps to the top address
  assign last_word = (addr_q == (len_q - ADDR_W'(1)));

  assign mem_addr  = addr_q;
  assign mem_wdata = word_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and state-decoded outputs
  always_comb begin
    state_d    = state_q;
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    cpu_hold   = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_start) state_d = RECV;
      end
      RECV: begin
        byte_ready = 1'b1;
        cpu_hold   = 1'b1;
        if (byte_valid && (cnt_q == 2'd3)) state_d = WRITE;
      end
      WRITE: begin
        mem_we   = 1'b1;
        cpu_hold = 1'b1;
        if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = DONE;
`endif
        end else begin
          state_d = RECV;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        byte_ready = 1'b1;
        cpu_hold   = 1'b1;
        if (byte_valid) state_d = DONE;
      end
`endif
      DONE: begin
        done = 1'b1;
        if (load_start) state_d = RECV;
      end
      default: state_d = IDLE;
    endcase
  end

  // Load length, word address, byte counter and word assembly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q  <= '0;
      addr_q <= '0;
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (load_start) begin
            len_q  <= load_len;
            addr_q <= '0;
            cnt_q  <= '0;
            word_q <= '0;
          end
        end
        RECV: begin
          // Shifting in from the top leaves byte 0 in [7:0] after four bytes
          if (byte_valid) begin
            word_q <= {byte_data, word_q[31:8]};
            cnt_q  <= cnt_q + 2'd1;
          end
        end
        WRITE: begin
          // The final increment wraps harmlessly: no write follows it
          addr_q <= addr_q + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] xor_q;
  logic       err_q;

  // Running XOR of data bytes and trailer comparison
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xor_q <= '0;
      err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (load_start) begin
            xor_q <= '0;
            err_q <= 1'b0;
          end
        end
        RECV: begin
          if (byte_valid) xor_q <= xor_q ^ byte_data;
        end
        CHECK: begin
          if (byte_valid) err_q <= (byte_data != xor_q);
        end
        default: ;
      endcase
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
